// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch PC sequencer feeding an in-order bundle queue.
// A request goes out only when the queue is sure to have room for its
// response, so the tail never overruns the head.
// Optional feature: define FETCH_EXT_PC_EN to add the exter_pc/exter_pc_en
// load ports; without it the external load is tied off.
module fetch_queue_unit #(
    parameter int unsigned         PC_WIDTH    = 16,
    parameter int unsigned         INST_WIDTH  = 16,
    parameter int unsigned         FETCH_WIDTH = 4,
    parameter int unsigned         QDEPTH      = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              has_mispredict,
    input  logic [PC_WIDTH-1:0]               pc_recovery,
    input  logic                              redirect_en,
    input  logic [PC_WIDTH-1:0]               redirect_pc,
`ifdef FETCH_EXT_PC_EN
    input  logic                              exter_pc_en,
    input  logic [PC_WIDTH-1:0]               exter_pc,
`endif
    input  logic                              stall_fetch,
    output logic                              imem_req,
    output logic [PC_WIDTH-1:0]               imem_addr,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] imem_rdata,
    output logic                              deq_valid,
    output logic [PC_WIDTH-1:0]               deq_pc,
    output logic [FETCH_WIDTH*INST_WIDTH-1:0] deq_inst,
    output logic [FETCH_WIDTH-1:0]            deq_mask,
    output logic [$clog2(QDEPTH):0]           q_count
);
    localparam int unsigned OFF_W = $clog2(FETCH_WIDTH);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BUN_W = FETCH_WIDTH * INST_WIDTH;

    logic                   ext_load;
    logic [PC_WIDTH-1:0]    ext_pc;
    logic [PC_WIDTH-1:0]    fpc;
    logic [PC_WIDTH-1:0]    fpc_next;
    logic                   inflight;
    logic [PC_WIDTH-1:0]    req_pc;
    logic [FETCH_WIDTH-1:0] req_mask;
    logic [FETCH_WIDTH-1:0] lane_mask;
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [CNT_W-1:0]       occupancy;
    logic                   flush_q;
    logic                   flush_any;
    logic                   push;
    logic                   pop;

    logic [PC_WIDTH-1:0]    pc_mem   [QDEPTH];
    logic [BUN_W-1:0]       inst_mem [QDEPTH];
    logic [FETCH_WIDTH-1:0] mask_mem [QDEPTH];

`ifdef FETCH_EXT_PC_EN
    assign ext_load = exter_pc_en;
    assign ext_pc   = exter_pc;
`else
    assign ext_load = 1'b0;
    assign ext_pc   = '0;
`endif

    // Queue-emptying events versus anything that invalidates the in-flight response.
    assign flush_q   = has_mispredict | ext_load;
    assign flush_any = flush_q | redirect_en;

    // Inflight counts as a reserved slot so a full queue is never pushed.
    assign occupancy = q_count + CNT_W'(inflight);
    assign imem_req  = (occupancy < CNT_W'(QDEPTH)) && !flush_any;
    assign imem_addr = {fpc[PC_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    assign push      = inflight && !flush_any;
    assign pop       = deq_valid && !stall_fetch && !flush_q;

    assign deq_valid = (q_count != '0);
    assign deq_pc    = pc_mem[head_ptr];
    assign deq_inst  = inst_mem[head_ptr];
    assign deq_mask  = deq_valid ? mask_mem[head_ptr] : '0;

    // Lanes below the fetch offset belong to the previous bundle and are masked off.
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask[i] = (OFF_W'(i) >= fpc[OFF_W-1:0]);
        end
    end

    // Next fetch PC: recovery, external load, redirect, sequential, hold.
    always_comb begin
        fpc_next = fpc;
        if (has_mispredict) begin
            fpc_next = pc_recovery;
        end else if (ext_load) begin
            fpc_next = ext_pc;
        end else if (redirect_en) begin
            fpc_next = redirect_pc;
        end else if (imem_req) begin
            fpc_next = imem_addr + PC_WIDTH'(FETCH_WIDTH);
        end
    end

    // Control state: fetch PC, outstanding request tag, queue pointers and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc      <= RESET_PC;
            inflight <= 1'b0;
            req_pc   <= '0;
            req_mask <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            q_count  <= '0;
        end else begin
            fpc      <= fpc_next;
            inflight <= imem_req;
            if (imem_req) begin
                req_pc   <= fpc;
                req_mask <= lane_mask;
            end
            if (flush_q) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                q_count  <= '0;
            end else begin
                if (push) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                end
                if (pop) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    q_count <= q_count + CNT_W'(1);
                end else if (pop && !push) begin
                    q_count <= q_count - CNT_W'(1);
                end
            end
        end
    end

    // Bundle storage needs no reset; deq_mask is gated by deq_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_ptr]   <= req_pc;
            inst_mem[tail_ptr] <= imem_rdata;
            mask_mem[tail_ptr] <= req_mask;
        end
    end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, PC width in bits.
REQ-002 SHALL have parameter INST_WIDTH, default 16, instruction width in bits.
REQ-003 SHALL have parameter FETCH_WIDTH, default 4, instructions per bundle; power of two, 2..8.
REQ-004 SHALL have parameter QDEPTH, default 4, bundle queue entries; power of two, 2..16.
REQ-005 SHALL have parameter RESET_PC, default 0, fetch PC after reset.
REQ-006 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port has_mispredict  input  1  ROB misprediction; flushes everything.
REQ-009 SHALL have port pc_recovery  input  PC_WIDTH  restart PC on misprediction.
REQ-010 SHALL have port redirect_en  input  1  front-end taken branch or jump.
REQ-011 SHALL have port redirect_pc  input  PC_WIDTH  target for redirect_en.
REQ-012 SHALL have port stall_fetch  input  1  decode cannot accept a bundle this cycle.
REQ-013 SHALL have port imem_req  output  1  memory read request.
REQ-014 SHALL have port imem_addr  output  PC_WIDTH  request PC, low log2(FETCH_WIDTH) bits forced to 0.
REQ-015 SHALL have port imem_rdata  input  FETCH_WIDTH*INST_WIDTH  bundle, valid exactly one cycle after imem_req; lane 0 in LSBs.
REQ-016 SHALL have port deq_valid  output  1  queue head is valid.
REQ-017 SHALL have port deq_pc  output  PC_WIDTH  unaligned PC of the head bundle.
REQ-018 SHALL have port deq_inst  output  FETCH_WIDTH*INST_WIDTH  head bundle instructions.
REQ-019 SHALL have port deq_mask  output  FETCH_WIDTH  per-lane valid of the head bundle.
REQ-020 SHALL have port q_count  output  log2(QDEPTH)+1  queue occupancy.

Function
REQ-021 Fetch PC register fpc SHALL update with priority: has_mispredict -> pc_recovery; exter_pc_en -> exter_pc (REQ-036); redirect_en -> redirect_pc; request issued -> {fpc aligned} + FETCH_WIDTH modulo 2^PC_WIDTH; otherwise hold.
REQ-022 imem_req SHALL be 1 iff q_count + inflight < QDEPTH and no mispredict, ext-PC load or redirect occurs in the same cycle; imem_addr = aligned fpc.
REQ-023 inflight SHALL be a 1-bit register set by imem_req and cleared the following cycle.
REQ-024 A response SHALL be written to the queue tail one cycle after the request, storing the unaligned request PC, imem_rdata, and mask bit i = 1 iff i >= fpc[log2(FETCH_WIDTH)-1:0].
REQ-025 A response whose in-flight request was followed by has_mispredict, exter_pc_en or redirect_en SHALL be discarded.
REQ-026 Pop SHALL occur when deq_valid=1 and stall_fetch=0; head advances by one entry.
REQ-027 deq_valid = (q_count != 0); deq_pc/deq_inst/deq_mask SHALL reflect the head combinationally from storage.
REQ-028 Simultaneous push and pop SHALL leave q_count unchanged; push into a full queue SHALL never occur (guaranteed by REQ-022).
REQ-029 Head/tail pointers SHALL wrap modulo QDEPTH.
REQ-030 has_mispredict SHALL empty the queue, clear inflight and suppress the pop in the same cycle; redirect_en SHALL keep queued bundles.
REQ-031 Latency: request at cycle N -> deq_valid at N+2 when the queue was empty.

Reset
REQ-032 While rst_n=0 at a rising edge: fpc=RESET_PC, pointers=0, q_count=0, inflight=0.
REQ-033 Outputs after reset: imem_req per REQ-022 (1), imem_addr=aligned RESET_PC, deq_valid=0, deq_mask=0, q_count=0.
REQ-034 Reset SHALL take priority over has_mispredict, redirect_en and any in-flight response.
REQ-035 Queue storage contents SHALL not require reset; deq_pc/deq_inst are don't-care while deq_valid=0.

Configuration
REQ-036 Macro FETCH_EXT_PC_EN defined: ports exter_pc (input PC_WIDTH) and exter_pc_en (input 1) SHALL exist; exter_pc_en=1 loads fpc from exter_pc, flushes the queue and discards in-flight data, priority below has_mispredict.
REQ-037 Macro FETCH_EXT_PC_EN undefined: those ports SHALL be absent and behaviour SHALL equal exter_pc_en=0.

Verification
REQ-038 Reset release, RESET_PC=0, stall_fetch=0 -> imem_addr 0,4,8,... on consecutive cycles; first deq_valid two cycles after first imem_req, deq_pc=0, deq_mask=4'b1111.
REQ-039 stall_fetch=1 held for 10 cycles -> q_count saturates at 4, imem_req=0 once q_count+inflight=4, no bundle lost or duplicated after release.
REQ-040 redirect_en with redirect_pc=16'h0036 -> next imem_addr=16'h0034, enqueued deq_pc=16'h0036, deq_mask=4'b1100; the in-flight response is discarded.
REQ-041 has_mispredict with pc_recovery=16'h0100 while q_count=3 and a pop is pending -> q_count=0 next cycle, no pop, next imem_addr=16'h0100.
REQ-042 fpc=16'hFFFC, sequential fetch -> next imem_addr=16'h0000 (wrap).
REQ-043 With FETCH_EXT_PC_EN: exter_pc_en=1, exter_pc=16'h0200, simultaneous has_mispredict, pc_recovery=16'h0080 -> next imem_addr=16'h0080.
